// File: rtl/lane_serializer.sv
// Lane serializer: captures a packed word of LANES fields and streams either one
// selected lane or every lane (wrapping from a start lane) over valid/ready.
module lane_serializer #(
    parameter  int LANE_W = 2,
    parameter  int LANES  = 4,
    localparam int IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [IDX_W-1:0]        sel,
    output logic [LANE_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LANES*LANE_W-1:0] r_word;
    logic [IDX_W-1:0]        r_beat;
    logic [IDX_W-1:0]        r_idx;
    logic [LANE_W-1:0]       r_data;
    logic                    r_last;

    logic                    w_accept;
    logic                    w_advance;
    logic [IDX_W-1:0]        w_start;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [LANE_W-1:0]       w_in_lanes   [LANES];
    logic [LANE_W-1:0]       w_word_lanes [LANES];

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            w_in_lanes[k]   = in_data[k*LANE_W +: LANE_W];
            w_word_lanes[k] = r_word[k*LANE_W +: LANE_W];
        end
    end

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_advance = out_ready && (r_state == SEND);
    assign w_start   = (32'(sel) >= 32'(LANES)) ? '0 : sel;
    assign w_idx_nxt = (r_idx == IDX_W'(LANES - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SEND;
            SEND:    if (out_ready && r_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Mode is not stored separately: single-lane words simply start with r_last set,
    // and a scan raises r_last when the beat counter reaches LANES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_beat <= '0;
            r_idx  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_word <= in_data;
            r_beat <= '0;
            r_idx  <= w_start;
            r_data <= w_in_lanes[w_start];
            r_last <= ~mode;
        end else if (w_advance && !r_last) begin
            r_beat <= r_beat + 1'b1;
            r_idx  <= w_idx_nxt;
            r_data <= w_word_lanes[w_idx_nxt];
            r_last <= (r_beat == IDX_W'(LANES - 2));
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == SEND);
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

endmodule
